fft_stream: RTL

//  Streaming, parametrised radix-2 DIT FFT/IFFT engine. Successor to the fully parallel fft_np: it adds

---
 rtl/fft_stream_pkg.sv | 55 +++++
 rtl/fft_stream_bfly.sv | 55 +++++
 rtl/fft_stream.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module : fft_stream_pkg
// Shared types and elaboration/arithmetic helpers for the streaming FFT.
// Rev    : 1.0
// ============================================================================
package fft_stream_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  localparam real c_PI = 3.14159265358979323846;

  function automatic int bitrev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) begin
      if (v[i]) r = r | (1 << (bits - 1 - i));
    end
    return r;
  endfunction

  // Forward-transform twiddle W^k = exp(-j*2*pi*k/n), scaled so that 1.0 = 2**(tw-2)
  function automatic int tw_re(input int k, input int n, input int tw);
    return int'($cos(2.0 * c_PI * real'(k) / real'(n)) * real'(1 << (tw - 2)));
  endfunction

  function automatic int tw_im(input int k, input int n, input int tw);
    return int'(-$sin(2.0 * c_PI * real'(k) / real'(n)) * real'(1 << (tw - 2)));
  endfunction

  function automatic int round_half_up(input int v, input int frac);
    return (v + (1 << (frac - 1))) >>> frac;
  endfunction

  // Keep the low w bits as a two's complement value
  function automatic int wrap_to(input int v, input int w);
    return (v <<< (32 - w)) >>> (32 - w);
  endfunction

  function automatic int saturate(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_stream_bfly.sv
`default_nettype none
// ============================================================================
// Module : fft_stream_bfly
// Combinational radix-2 DIT butterfly: top = a + b*w, bot = a - b*w.
// Rev    : 1.0
// ============================================================================
module fft_stream_bfly
  import fft_stream_pkg::*;
#(
  parameter int CW       = 8,
  parameter int TW_WIDTH = 10,
  parameter int SCALE    = 1
) (
  input  logic [2*CW-1:0]       a,
  input  logic [2*CW-1:0]       b,
  input  logic [2*TW_WIDTH-1:0] w,
  output logic [2*CW-1:0]       top,
  output logic [2*CW-1:0]       bot,
  output logic                  sat
);

  logic signed [CW-1:0]       w_ar, w_ai, w_br, w_bi;
  logic signed [TW_WIDTH-1:0] w_wr, w_wi;
  int                         w_tr, w_ti;
  int                         w_sum [4];
  int                         w_scl [4];
  logic signed [CW-1:0]       w_res [4];

  assign {w_ai, w_ar} = a;
  assign {w_bi, w_br} = b;
  assign {w_wi, w_wr} = w;

  // Index 0/1: top re/im, 2/3: bottom re/im
  always_comb begin
    w_tr = wrap_to(round_half_up(int'(w_br) * int'(w_wr) - int'(w_bi) * int'(w_wi),
                                 TW_WIDTH - 2), CW + 1);
    w_ti = wrap_to(round_half_up(int'(w_br) * int'(w_wi) + int'(w_bi) * int'(w_wr),
                                 TW_WIDTH - 2), CW + 1);
    w_sum[0] = int'(w_ar) + w_tr;
    w_sum[1] = int'(w_ai) + w_ti;
    w_sum[2] = int'(w_ar) - w_tr;
    w_sum[3] = int'(w_ai) - w_ti;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_scl[i] = (SCALE != 0) ? (w_sum[i] >>> 1) : w_sum[i];
      w_res[i] = CW'(saturate(w_scl[i], CW));
      if (int'(w_res[i]) != w_scl[i]) sat = 1'b1;
    end
  end

  assign top = {w_res[1], w_res[0]};
  assign bot = {w_res[3], w_res[2]};

endmodule
`default_nettype wire

// File: rtl/fft_stream.sv
`default_nettype none
// ============================================================================
// Module : fft_stream
// Streaming in-place radix-2 DIT FFT/IFFT with valid/ready frame I/O.
// Rev    : 1.0
// ============================================================================
module fft_stream
  import fft_stream_pkg::*;
#(
  parameter int N            = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int TW_WIDTH     = 10,
  parameter int SCALE        = 1
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    cfg_inverse,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [SAMPLE_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    ovf,
  output logic                    busy
);

  localparam int S  = $clog2(N);
  localparam int CW = SAMPLE_WIDTH / 2;
  localparam int BW = S - 1;
  localparam int SW = $clog2(S);

  localparam logic [S-1:0]  c_CNT_MAX   = '1;
  localparam logic [S-1:0]  c_ONE       = S'(1);
  localparam logic [SW-1:0] c_STAGE_MAX = SW'(S - 1);

  state_t                    r_state, w_state_nxt;
  logic [S-1:0]              r_cnt, r_ocnt;
  logic [BW-1:0]             r_bfly;
  logic [SW-1:0]             r_stage;
  logic                      r_inv, r_ovf;
  logic [SAMPLE_WIDTH-1:0]   r_buf [N];

  logic                      w_in_acc, w_out_acc, w_bfly_last, w_stage_last;
  logic [S-1:0]              w_ld_addr, w_top, w_bot;
  logic [BW-1:0]             w_mask, w_pos, w_hi, w_k;
  logic [2*TW_WIDTH-1:0]     w_rom [N/2];
  logic [TW_WIDTH-1:0]       w_tw_re, w_tw_im;
  logic [2*TW_WIDTH-1:0]     w_tw;
  logic [SAMPLE_WIDTH-1:0]   w_bf_top, w_bf_bot;
  logic                      w_bf_sat;

  for (genvar gi = 0; gi < N/2; gi++) begin : g_tw
    localparam logic [TW_WIDTH-1:0] c_RE = TW_WIDTH'(tw_re(gi, N, TW_WIDTH));
    localparam logic [TW_WIDTH-1:0] c_IM = TW_WIDTH'(tw_im(gi, N, TW_WIDTH));
    assign w_rom[gi] = {c_IM, c_RE};
  end

  assign w_in_acc     = s_valid && s_ready;
  assign w_out_acc    = m_valid && m_ready;
  assign w_bfly_last  = (r_bfly == '1);
  assign w_stage_last = (r_stage == c_STAGE_MAX);
  assign w_ld_addr    = S'(bitrev(int'(r_cnt), S));

  // Butterfly pair and twiddle index for stage r_stage, butterfly r_bfly
  assign w_mask  = ~({BW{1'b1}} << r_stage);
  assign w_pos   = r_bfly & w_mask;
  assign w_hi    = r_bfly >> r_stage;
  assign w_top   = (({1'b0, w_hi} << r_stage) << 1) | {1'b0, w_pos};
  assign w_bot   = w_top | (c_ONE << r_stage);
  assign w_k     = w_pos << (c_STAGE_MAX - r_stage);

  assign {w_tw_im, w_tw_re} = w_rom[w_k];
  assign w_tw = {(r_inv ? -w_tw_im : w_tw_im), w_tw_re};

  fft_stream_bfly #(
    .CW       (CW),
    .TW_WIDTH (TW_WIDTH),
    .SCALE    (SCALE)
  ) u_bfly (
    .a   (r_buf[w_top]),
    .b   (r_buf[w_bot]),
    .w   (w_tw),
    .top (w_bf_top),
    .bot (w_bf_bot),
    .sat (w_bf_sat)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= ST_LOAD;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:    if (w_in_acc && r_cnt == c_CNT_MAX) w_state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (w_bfly_last && w_stage_last)    w_state_nxt = ST_UNLOAD;
      ST_UNLOAD:  if (w_out_acc && m_last)            w_state_nxt = ST_LOAD;
      default:    w_state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b1;
    case (r_state)
      ST_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b0;
      end
      ST_UNLOAD: m_valid = 1'b1;
      default: ;
    endcase
    m_last = m_valid && (r_ocnt == c_CNT_MAX);
    m_data = m_valid ? r_buf[r_ocnt] : '0;
  end

  assign ovf = r_ovf;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt   <= '0;
      r_ocnt  <= '0;
      r_bfly  <= '0;
      r_stage <= '0;
      r_inv   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_in_acc) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '0)       r_inv <= cfg_inverse;
        if (r_cnt == c_CNT_MAX) r_ovf <= 1'b0;
      end
      if (r_state == ST_COMPUTE) begin
        if (w_bf_sat) r_ovf <= 1'b1;
        r_bfly <= r_bfly + 1'b1;
        if (w_bfly_last) r_stage <= w_stage_last ? '0 : r_stage + 1'b1;
      end
      if (w_out_acc) r_ocnt <= r_ocnt + 1'b1;
    end
  end

  // Sample storage carries no reset; its contents are rewritten by every frame
  always_ff @(posedge clk) begin
    if (w_in_acc) r_buf[w_ld_addr] <= s_data;
    if (r_state == ST_COMPUTE) begin
      r_buf[w_top] <= w_bf_top;
      r_buf[w_bot] <= w_bf_bot;
    end
  end

endmodule
`default_nettype wire
